ahb_slave_mux_n: RTL and testbench

Parametrised single-master AHB-Lite slave-side interconnect for the system AHB. It replaces the fixed decoder, default slave and four-port slave multiplexer with one block:
- a NUM_SLAVES-way base/mask address decoder;
- a data-phase select register;
- an integrated default slave that returns the two-cycle ERROR response;
- a wait-state timeout monitor that raises a sticky interrupt.

It sits between the core's system AHB master port and the peripheral slaves (BRAM, future APB bridge, etc.).

---
 rtl/ahb_pkg.sv | 19 +
 rtl/ahb_default_slave.sv | 45 ++++
 rtl/ahb_slave_mux_n.sv | 131 +++++++++++++
 tb/tb_ahb_slave_mux_n.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// system AHB interconnect.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped address space: answers NONSEQ/SEQ with the
// two-cycle ERROR response and lets IDLE/BUSY complete as zero-wait OKAY.
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic unmapped_req,
    input  logic hready,
    output logic readyout,
    output logic resp
);

    ds_state_t state, state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        readyout  = 1'b1;
        resp      = HRESP_OKAY;
        case (state)
            DS_IDLE: begin
                if (hready && unmapped_req) state_nxt = DS_ERR1;
            end
            DS_ERR1: begin
                readyout  = 1'b0;
                resp      = HRESP_ERROR;
                state_nxt = DS_ERR2;
            end
            DS_ERR2: begin
                resp      = HRESP_ERROR;
                state_nxt = (hready && unmapped_req) ? DS_ERR1 : DS_IDLE;
            end
            default: state_nxt = DS_IDLE;
        endcase
    end

endmodule

// File: rtl/ahb_slave_mux_n.sv
// Single-master AHB-Lite slave-side interconnect: base/mask decoder, data-phase
// select register, response mux, default slave and wait-state timeout monitor.
module ahb_slave_mux_n
    import ahb_pkg::*;
#(
    parameter int                        NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0]  ADDR_BASE      = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0]  ADDR_MASK      = {NUM_SLAVES{32'hFFFF_FFFF}},
    parameter int                        TIMEOUT_CYCLES = 256
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HREADY,
    output logic [NUM_SLAVES-1:0]   HSEL_O,
    input  logic [NUM_SLAVES-1:0]   HREADYOUT_I,
    input  logic [NUM_SLAVES-1:0]   HRESP_I,
    input  logic [32*NUM_SLAVES-1:0] HRDATA_I,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [31:0]             HRDATA,
    input  logic                    timeout_clr,
    output logic                    timeout_irq,
    output logic [4:0]              timeout_id
);

    // Index NUM_SLAVES stands for the internal default slave.
    localparam logic [4:0]  DEF_IDX  = 5'(NUM_SLAVES);
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [4:0]  dec_idx;
    logic        dec_hit;
    logic        unmapped_req;
    logic [4:0]  dsel_idx_p1;
    logic        dsel_vld_p1;
    logic        dsel_real;
    logic        ds_ready;
    logic        ds_resp;
    logic [15:0] cnt;
    logic        to_hit;

    // Address phase: lowest matching index wins on overlap.
    always_comb begin
        dec_idx = DEF_IDX;
        dec_hit = 1'b0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((HADDR & ADDR_MASK[32*i +: 32]) == ADDR_BASE[32*i +: 32]) begin
                dec_idx = 5'(i);
                dec_hit = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SLAVES; i++) begin
            HSEL_O[i] = dec_hit && (dec_idx == 5'(i));
        end
    end

    assign unmapped_req = !dec_hit &&
                          ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

    // Address -> data phase boundary.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dsel_idx_p1 <= '0;
            dsel_vld_p1 <= 1'b0;
        end else if (HREADY) begin
            dsel_idx_p1 <= dec_idx;
            dsel_vld_p1 <= 1'b1;
        end
    end

    assign dsel_real = dsel_vld_p1 && (dsel_idx_p1 < DEF_IDX);

    ahb_default_slave u_default_slave (
        .clk          (HCLK),
        .rst          (HRESET),
        .unmapped_req (unmapped_req),
        .hready       (HREADY),
        .readyout     (ds_ready),
        .resp         (ds_resp)
    );

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        if (dsel_vld_p1 && (dsel_idx_p1 == DEF_IDX)) begin
            HREADYOUT = ds_ready;
            HRESP     = ds_resp;
        end else begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dsel_vld_p1 && (dsel_idx_p1 == 5'(i))) begin
                    HREADYOUT = HREADYOUT_I[i];
                    HRESP     = HRESP_I[i];
                    HRDATA    = HRDATA_I[32*i +: 32];
                end
            end
        end
    end

    // A zero limit leaves cnt parked at 0 == TO_LIMIT, so the monitor stays idle.
    assign to_hit = (TO_LIMIT != 16'd0) && dsel_real && !HREADYOUT &&
                    (cnt == TO_LIMIT - 16'd1);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            cnt <= '0;
        end else if (HREADYOUT) begin
            cnt <= '0;
        end else if (dsel_real && (cnt != TO_LIMIT)) begin
            cnt <= cnt + 16'd1;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            timeout_irq <= 1'b0;
            timeout_id  <= '0;
        end else begin
            if (to_hit) begin
                timeout_irq <= 1'b1;
            end else if (timeout_clr) begin
                timeout_irq <= 1'b0;
            end
            if (to_hit && !timeout_irq) begin
                timeout_id <= dsel_idx_p1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mux_n.sv
// Bench for ahb_slave_mux_n: per-cycle vector table plus stall/timeout/reset sequences.
module tb_ahb_slave_mux_n;

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [1:0]  rdy_i;
        logic [1:0]  resp_i;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        clr;
        logic [1:0]  e_hsel;
        logic        e_rdy;
        logic        e_resp;
        logic [31:0] e_data;
        logic        e_irq;
        logic [4:0]  e_id;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hready;
    logic [1:0]  hsel_o;
    logic [1:0]  hreadyout_i;
    logic [1:0]  hresp_i;
    logic [63:0] hrdata_i;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        timeout_clr;
    logic        timeout_irq;
    logic [4:0]  timeout_id;

    int n_cmp = 0;
    int n_err = 0;
    vec_t exp_q[$];
    vec_t tbl[18];

    always #5 clk = ~clk;
    assign hready = hreadyout;

    ahb_slave_mux_n #(
        .NUM_SLAVES     (2),
        .ADDR_BASE      ({32'h4000_0000, 32'h2000_0000}),
        .ADDR_MASK      ({32'hF000_0000, 32'hFFFC_0000}),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .HCLK        (clk),
        .HRESET      (rst),
        .HADDR       (haddr),
        .HTRANS      (htrans),
        .HREADY      (hready),
        .HSEL_O      (hsel_o),
        .HREADYOUT_I (hreadyout_i),
        .HRESP_I     (hresp_i),
        .HRDATA_I    (hrdata_i),
        .HREADYOUT   (hreadyout),
        .HRESP       (hresp),
        .HRDATA      (hrdata),
        .timeout_clr (timeout_clr),
        .timeout_irq (timeout_irq),
        .timeout_id  (timeout_id)
    );

    function automatic vec_t mk(
        input logic [31:0] addr, input logic [1:0] trans, input logic [1:0] rdy_i,
        input logic [1:0] resp_i, input logic [31:0] d0, input logic [31:0] d1,
        input logic clr, input logic [1:0] e_hsel, input logic e_rdy, input logic e_resp,
        input logic [31:0] e_data, input logic e_irq, input logic [4:0] e_id);
        vec_t v;
        v.addr = addr;     v.trans = trans;   v.rdy_i = rdy_i;   v.resp_i = resp_i;
        v.d0 = d0;         v.d1 = d1;         v.clr = clr;
        v.e_hsel = e_hsel; v.e_rdy = e_rdy;   v.e_resp = e_resp; v.e_data = e_data;
        v.e_irq = e_irq;   v.e_id = e_id;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        haddr       = v.addr;
        htrans      = v.trans;
        hreadyout_i = v.rdy_i;
        hresp_i     = v.resp_i;
        hrdata_i    = {v.d1, v.d0};
        timeout_clr = v.clr;
    endtask

    // Drive one cycle, queue its expectation, compare mid-cycle, step to next edge.
    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        drive(v);
        exp_q.push_back(v);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s.queue: got empty, expected entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".hsel"}, 32'(hsel_o), 32'(e.e_hsel));
            chk({tag, ".hreadyout"}, 32'(hreadyout), 32'(e.e_rdy));
            chk({tag, ".hresp"}, 32'(hresp), 32'(e.e_resp));
            chk({tag, ".hrdata"}, hrdata, e.e_data);
            chk({tag, ".irq"}, 32'(timeout_irq), 32'(e.e_irq));
            chk({tag, ".id"}, 32'(timeout_id), 32'(e.e_id));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        tbl[0]  = mk(32'h2000_0010, NS, 2'b11, 2'b00, 32'hDEADBEEF, 32'h1111_1111, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        tbl[1]  = mk(32'h8000_0000, NS, 2'b11, 2'b00, 32'hDEADBEEF, 32'h1111_1111, 1'b0, 2'b00, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 5'd0);
        tbl[2]  = mk(32'h8000_0000, ID, 2'b11, 2'b00, 32'hDEADBEEF, 32'h1111_1111, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 5'd0);
        tbl[3]  = mk(32'h8000_0000, ID, 2'b11, 2'b00, 32'hDEADBEEF, 32'h1111_1111, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0, 1'b0, 5'd0);
        tbl[4]  = mk(32'h4000_0000, NS, 2'b11, 2'b00, 32'hDEADBEEF, 32'h1111_1111, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        tbl[5]  = mk(32'h2000_0020, NS, 2'b01, 2'b00, 32'hDEADBEEF, 32'hCAFE_0001, 1'b0, 2'b01, 1'b0, 1'b0, 32'hCAFE_0001, 1'b0, 5'd0);
        tbl[6]  = mk(32'h2000_0020, NS, 2'b01, 2'b00, 32'hDEADBEEF, 32'hCAFE_0002, 1'b0, 2'b01, 1'b0, 1'b0, 32'hCAFE_0002, 1'b0, 5'd0);
        tbl[7]  = mk(32'h2000_0020, NS, 2'b11, 2'b00, 32'hDEADBEEF, 32'hCAFE_F00D, 1'b0, 2'b01, 1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, 5'd0);
        tbl[8]  = mk(32'h0000_0000, ID, 2'b11, 2'b00, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 2'b00, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 5'd0);
        tbl[9]  = mk(32'h4000_1234, ID, 2'b11, 2'b00, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0);
        tbl[10] = mk(32'h2003_FFFC, NS, 2'b01, 2'b10, 32'h0, 32'hBAD0_BAD0, 1'b0, 2'b01, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 5'd0);
        tbl[11] = mk(32'h2003_FFFC, NS, 2'b11, 2'b10, 32'h0, 32'hBAD0_BAD1, 1'b0, 2'b01, 1'b1, 1'b1, 32'hBAD0_BAD1, 1'b0, 5'd0);
        tbl[12] = mk(32'h2004_0000, NS, 2'b11, 2'b00, 32'hAABB_CCDD, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 32'hAABB_CCDD, 1'b0, 5'd0);
        tbl[13] = mk(32'h3000_0000, SQ, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, 5'd0);
        tbl[14] = mk(32'h3000_0000, SQ, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b1, 32'h0, 1'b0, 5'd0);
        tbl[15] = mk(32'h4000_0000, ID, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, 5'd0);
        tbl[16] = mk(32'h4000_0000, ID, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b10, 1'b1, 1'b1, 32'h0, 1'b0, 5'd0);
        tbl[17] = mk(32'h0000_0000, ID, 2'b11, 2'b00, 32'h0, 32'h5A5A_5A5A, 1'b0, 2'b00, 1'b1, 1'b0, 32'h5A5A_5A5A, 1'b0, 5'd0);

        rst = 1'b1;
        drive(mk(32'h0, ID, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0));
        #3;
        chk("reset.hreadyout", 32'(hreadyout), 32'd1);
        chk("reset.hresp", 32'(hresp), 32'd0);
        chk("reset.hrdata", hrdata, 32'd0);
        chk("reset.irq", 32'(timeout_irq), 32'd0);
        chk("reset.id", 32'(timeout_id), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Slave1 stalls 12 cycles: flag rises in stall cycle 9.
        apply(mk(32'h4000_0000, NS, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0), "to_addr");
        for (int k = 1; k <= 12; k++) begin
            v = mk(32'h0, ID, 2'b01, 2'b00, 32'h0, 32'h7700_0000 + 32'(k), 1'b0, 2'b00, 1'b0, 1'b0,
                   32'h7700_0000 + 32'(k), (k >= 9), (k >= 9) ? 5'd1 : 5'd0);
            apply(v, $sformatf("to_stall%0d", k));
        end
        apply(mk(32'h0, ID, 2'b11, 2'b00, 32'h0, 32'h7700_00FF, 1'b0, 2'b00, 1'b1, 1'b0, 32'h7700_00FF, 1'b1, 5'd1), "to_done");

        // Slave0 stalls past the limit while the flag is set: id must hold at 1.
        apply(mk(32'h2000_0000, NS, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h0, 1'b1, 5'd1), "hold_addr");
        for (int k = 1; k <= 10; k++) begin
            v = mk(32'h0, ID, 2'b10, 2'b00, 32'h6600_0000 + 32'(k), 32'h0, 1'b0, 2'b00, 1'b0, 1'b0,
                   32'h6600_0000 + 32'(k), 1'b1, 5'd1);
            apply(v, $sformatf("hold_stall%0d", k));
        end
        apply(mk(32'h0, ID, 2'b11, 2'b00, 32'h6600_00FF, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h6600_00FF, 1'b1, 5'd1), "hold_done");

        apply(mk(32'h0, ID, 2'b11, 2'b00, 32'h0, 32'h0, 1'b1, 2'b00, 1'b1, 1'b0, 32'h0, 1'b1, 5'd1), "clr_pulse");
        apply(mk(32'h4000_0000, NS, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 5'd1), "clr_after");

        // Clear lands on the same edge as the set: set wins.
        for (int k = 1; k <= 9; k++) begin
            v = mk(32'h0, ID, 2'b01, 2'b00, 32'h0, 32'h5500_0000 + 32'(k), (k == 8), 2'b00, 1'b0, 1'b0,
                   32'h5500_0000 + 32'(k), (k >= 9), 5'd1);
            apply(v, $sformatf("setclr_stall%0d", k));
        end
        apply(mk(32'h8000_0000, NS, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b1, 5'd1), "setclr_done");

        // Reset during the ERR1 cycle of an unmapped access.
        drive(mk(32'h0, ID, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0));
        @(negedge clk);
        chk("err1.hreadyout", 32'(hreadyout), 32'd0);
        chk("err1.hresp", 32'(hresp), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_err1.hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_err1.hresp", 32'(hresp), 32'd0);
        chk("rst_err1.hrdata", hrdata, 32'd0);
        chk("rst_err1.irq", 32'(timeout_irq), 32'd0);
        chk("rst_err1.id", 32'(timeout_id), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        apply(mk(32'h0, ID, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0), "post_rst_idle");
        apply(mk(32'h4000_0000, NS, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b10, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0), "post_rst_fsm");

        // Reset during a slave wait state.
        apply(mk(32'h0, ID, 2'b01, 2'b00, 32'h0, 32'h44, 1'b0, 2'b00, 1'b0, 1'b0, 32'h44, 1'b0, 5'd0), "wait_stall");
        @(negedge clk);
        chk("wait_stall2.hreadyout", 32'(hreadyout), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_wait.hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_wait.hresp", 32'(hresp), 32'd0);
        chk("rst_wait.hrdata", hrdata, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        apply(mk(32'h0, ID, 2'b11, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0, 5'd0), "post_rst_wait");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
